// File: rtl/ctrl_fsm_mc.sv
// Multicycle control unit for the 32-bit accumulator/stack CPU: sequences fetch/decode/execute,
// memory wait states, branches, stack ops and the I/O handshake with optional timeout.
module ctrl_fsm_mc #(
    parameter int unsigned OP_W       = 6,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned IO_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            neg,
    input  logic            enter,
    output logic [3:0]      state,
    output logic            pc_we,
    output logic            ir_we,
    output logic            reg_we,
    output logic            mem_we,
    output logic            mem_re,
    output logic            in_en,
    output logic            out_en,
    output logic            push,
    output logic            pop,
    output logic [1:0]      alu_op,
    output logic [2:0]      sel_pc,
    output logic            sel_alu_a,
    output logic [1:0]      sel_alu_b,
    output logic [1:0]      sel_wb,
    output logic            sel_mem_addr,
    output logic            sel_mem_data,
    output logic            halted,
    output logic            illegal,
    output logic            io_timeout
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExec    = 4'd2,
        StWb      = 4'd3,
        StBranch  = 4'd4,
        StMaddr   = 4'd5,
        StMwait   = 4'd6,
        StMwrite  = 4'd7,
        StJump    = 4'd8,
        StStk     = 4'd9,
        StInWait  = 4'd10,
        StOutWait = 4'd11,
        StRelease = 4'd12,
        StTrap    = 4'd13,
        StHalt    = 4'd14
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        illegal_q;
    logic        io_timeout_q;

    logic [5:0] op;
    logic       op_hi;

    assign op = opcode[5:0];

    generate
        if (OP_W > 6) begin : g_op_hi
            assign op_hi = |opcode[OP_W-1:6];
        end else begin : g_no_op_hi
            assign op_hi = 1'b0;
        end
    endgenerate

    logic is_r, is_imm, is_br, is_ld, is_st, is_jump, is_lstk, is_sstk;
    logic is_hlt, is_in, is_out, is_ill;

    always_comb begin
        is_r    = !op_hi && (op == 6'd0);
        is_imm  = !op_hi && (op >= 6'd1) && (op <= 6'd9);
        is_br   = !op_hi && (op >= 6'd10) && (op <= 6'd13);
        is_ld   = !op_hi && ((op == 6'd15) || (op == 6'd17));
        is_st   = !op_hi && ((op == 6'd14) || (op == 6'd16));
        is_jump = !op_hi && (op >= 6'd21) && (op <= 6'd23);
        is_lstk = !op_hi && (op == 6'd28);
        is_sstk = !op_hi && (op == 6'd29);
        is_hlt  = !op_hi && (op == 6'd18);
        is_in   = !op_hi && (op == 6'd19);
        is_out  = !op_hi && (op == 6'd20);
        is_ill  = !(is_r || is_imm || is_br || is_ld || is_st || is_jump || is_lstk ||
                    is_sstk || is_hlt || is_in || is_out);
    end

    logic br_taken;
    logic mwait_done;
    logic io_hit;
    logic io_waiting;

    always_comb begin
        br_taken = 1'b0;
        case (op)
            6'd10:   br_taken = zero;
            6'd11:   br_taken = !zero;
            6'd12:   br_taken = neg;
            6'd13:   br_taken = !neg && !zero;
            default: br_taken = 1'b0;
        endcase
    end

    assign mwait_done = (cnt_q == 16'(MEM_LAT - 1));
    assign io_waiting = (state_q == StInWait) || (state_q == StOutWait);
    // enter on the final counted cycle takes priority over the timeout
    assign io_hit     = (IO_TIMEOUT != 0) && (cnt_q == 16'(IO_TIMEOUT - 1)) && !enter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFetch;
            cnt_q        <= '0;
            illegal_q    <= 1'b0;
            io_timeout_q <= 1'b0;
        end else begin
            cnt_q <= '0;
            case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    if (is_ill)                      state_q <= StTrap;
                    else if (is_r || is_imm)         state_q <= StExec;
                    else if (is_br)                  state_q <= StBranch;
                    else if (is_ld || is_st)         state_q <= StMaddr;
                    else if (is_jump)                state_q <= StJump;
                    else if (is_lstk)                state_q <= StStk;
                    else if (is_sstk)                state_q <= StMwrite;
                    else if (is_in)                  state_q <= StInWait;
                    else if (is_out)                 state_q <= StOutWait;
                    else                             state_q <= StHalt;
                end
                StExec:   state_q <= StWb;
                StWb:     state_q <= StFetch;
                StBranch: state_q <= StFetch;
                StMaddr: begin
                    if (!is_ld)             state_q <= StMwrite;
                    else if (MEM_LAT == 0)  state_q <= StWb;
                    else                    state_q <= StMwait;
                end
                StMwait: begin
                    if (mwait_done) state_q <= StWb;
                    else            cnt_q   <= cnt_q + 16'd1;
                end
                StMwrite, StJump, StStk: state_q <= StFetch;
                StInWait, StOutWait: begin
                    if (enter) begin
                        state_q <= StRelease;
                    end else if (io_hit) begin
                        io_timeout_q <= 1'b1;
                        state_q      <= StFetch;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StRelease: if (!enter) state_q <= StFetch;
                StTrap: begin
                    illegal_q <= 1'b1;
                    state_q   <= StFetch;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        in_en        = 1'b0;
        out_en       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        alu_op       = 2'b00;
        sel_pc       = 3'd0;
        sel_alu_a    = 1'b0;
        sel_alu_b    = 2'd0;
        sel_wb       = 2'd0;
        sel_mem_addr = 1'b0;
        sel_mem_data = 1'b0;
        case (state_q)
            StFetch: begin
                ir_we     = 1'b1;
                mem_re    = 1'b1;
                sel_alu_b = 2'd1;
            end
            StDecode: pc_we = !(is_hlt || is_ill);
            StExec: begin
                sel_alu_a = 1'b1;
                if (is_r) begin
                    alu_op    = 2'b10;
                    sel_alu_b = 2'd0;
                end else begin
                    alu_op    = 2'b11;
                    sel_alu_b = 2'd3;
                end
            end
            StWb: begin
                reg_we = 1'b1;
                sel_wb = is_ld ? 2'd1 : 2'd0;
            end
            StBranch: begin
                alu_op    = 2'b01;
                sel_alu_a = 1'b1;
                sel_pc    = 3'd1;
                pc_we     = br_taken;
            end
            StMaddr: begin
                sel_alu_a = 1'b1;
                sel_alu_b = 2'd3;
                alu_op    = ((op == 6'd14) || (op == 6'd15)) ? 2'b11 : 2'b00;
            end
            StMwait: begin
                mem_re       = 1'b1;
                sel_mem_addr = 1'b1;
            end
            StMwrite: begin
                mem_we       = 1'b1;
                sel_mem_addr = 1'b1;
                sel_mem_data = is_sstk;
                pop          = is_sstk;
            end
            StJump: begin
                pc_we = 1'b1;
                case (op)
                    6'd22: begin
                        sel_pc = 3'd2;
                        push   = 1'b1;
                    end
                    6'd23: begin
                        sel_pc = 3'd3;
                        pop    = 1'b1;
                    end
                    default: sel_pc = 3'd2;
                endcase
            end
            StStk: begin
                sel_alu_a = 1'b1;
                push      = 1'b1;
            end
            StInWait: begin
                in_en  = 1'b1;
                sel_wb = 2'd2;
                reg_we = enter;
            end
            StOutWait: out_en = 1'b1;
            StTrap: begin
                pc_we  = 1'b1;
                sel_pc = 3'd4;
            end
            default: ;
        endcase
        // no write or stack side effect may leak out while reset is held
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            reg_we = 1'b0;
            mem_we = 1'b0;
            push   = 1'b0;
            pop    = 1'b0;
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == StHalt) && !reset;
    assign illegal    = illegal_q || ((state_q == StTrap) && !reset);
    assign io_timeout = io_timeout_q || (io_waiting && io_hit && !reset);

endmodule
